// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC mode encodings,
// default reset address and the clog2 helper used for port sizing.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        PCM_INC    = 3'd0,
        PCM_BRANCH = 3'd1,
        PCM_JUMP   = 3'd2,
        PCM_JR     = 3'd3,
        PCM_CALL   = 3'd4,
        PCM_RET    = 3'd5
    } pc_mode_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_1000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// a pop on empty leaves the state untouched. Error pulses are combinational.
module ras_stack
    import pc_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 8,
    localparam int PW = clog2(RAS_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CW-1:0]    cnt_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_evt_o,
    output logic             unf_evt_o
);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    sp_q, sp_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign full_o    = (cnt_q == CW'(RAS_DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign cnt_o     = cnt_q;
    // sp_q points at the next free slot, so the newest entry sits just below it.
    assign top_o     = mem_q[sp_q - PW'(1)];
    assign ovf_evt_o = push_i & full_o;
    assign unf_evt_o = pop_i & empty_o;

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push_i) begin
            sp_d = sp_q + PW'(1);
            if (!full_o) cnt_d = cnt_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            sp_d  = sp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            if (push_i) mem_q[sp_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit with six next-PC modes, a return-address stack and
// sticky error flags. Define PC_UNIT_TRACE_EN to capture redirect source PCs.
module pc_unit_ras
    import pc_unit_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_PC  = PC_RESET_DEFAULT,
    parameter int          RAS_DEPTH = 8,
    parameter int          IMM_W     = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      LOAD,
    input  logic [2:0]                MODE,
    input  logic                      BR_TAKEN,
    input  logic [IMM_W-1:0]          IMM,
    input  logic [25:0]               TARGET,
    input  logic [WIDTH-1:0]          REG_TGT,
    input  logic                      CLR_ERR,
    output logic [WIDTH-1:0]          PC,
    output logic [WIDTH-1:0]          PC_INC,
    output logic [clog2(RAS_DEPTH):0] RAS_CNT,
    output logic                      RAS_EMPTY,
    output logic                      RAS_FULL,
    output logic                      RAS_OVF,
    output logic                      RAS_UNF,
    output logic                      BAD_MODE,
    output logic [WIDTH-1:0]          LAST_REDIR
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc, imm_ext, tgt_ext, ras_top;
    logic             push, pop, bad_evt, ovf_evt, unf_evt;
    logic             ovf_q, unf_q, bad_q;

    assign pc_inc  = pc_q + WIDTH'(1);
    assign imm_ext = WIDTH'($signed(IMM));
    assign tgt_ext = WIDTH'(TARGET);

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .cnt_o       (RAS_CNT),
        .empty_o     (RAS_EMPTY),
        .full_o      (RAS_FULL),
        .ovf_evt_o   (ovf_evt),
        .unf_evt_o   (unf_evt)
    );

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        bad_evt = 1'b0;
        if (LOAD) begin
            case (pc_mode_e'(MODE))
                PCM_INC:    pc_d = pc_inc;
                PCM_BRANCH: pc_d = BR_TAKEN ? pc_inc + imm_ext : pc_inc;
                PCM_JUMP:   pc_d = tgt_ext;
                PCM_JR:     pc_d = REG_TGT;
                PCM_CALL: begin
                    pc_d = tgt_ext;
                    push = 1'b1;
                end
                PCM_RET: begin
                    // Empty stack falls back to the software-provided target.
                    pc_d = RAS_EMPTY ? REG_TGT : ras_top;
                    pop  = 1'b1;
                end
                default: begin
                    pc_d    = pc_inc;
                    bad_evt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc_q  <= WIDTH'(RESET_PC);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            // A same-cycle error event outranks CLR_ERR.
            ovf_q <= ovf_evt | (ovf_q & ~CLR_ERR);
            unf_q <= unf_evt | (unf_q & ~CLR_ERR);
            bad_q <= bad_evt | (bad_q & ~CLR_ERR);
        end
    end

    assign PC       = pc_q;
    assign PC_INC   = pc_inc;
    assign RAS_OVF  = ovf_q;
    assign RAS_UNF  = unf_q;
    assign BAD_MODE = bad_q;

`ifdef PC_UNIT_TRACE_EN
    logic             redirect;
    logic [WIDTH-1:0] redir_q;

    always_comb begin
        redirect = 1'b0;
        if (LOAD) begin
            case (pc_mode_e'(MODE))
                PCM_BRANCH:                      redirect = BR_TAKEN;
                PCM_JUMP, PCM_JR, PCM_CALL, PCM_RET: redirect = 1'b1;
                default:                         redirect = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) redir_q <= '0;
        else if (redirect) redir_q <= pc_q;
    end

    assign LAST_REDIR = redir_q;
`else
    assign LAST_REDIR = '0;
`endif

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras: driver queues expected state per cycle,
// a monitor pops and compares one entry after every rising edge.
module tb_pc_unit_ras;

    logic        CLK = 1'b0;
    logic        RST, LOAD, BR_TAKEN, CLR_ERR;
    logic [2:0]  MODE;
    logic [15:0] IMM;
    logic [25:0] TARGET;
    logic [31:0] REG_TGT;
    logic [31:0] PC, PC_INC, LAST_REDIR;
    logic [3:0]  RAS_CNT;
    logic        RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF, BAD_MODE;

    pc_unit_ras dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .MODE(MODE), .BR_TAKEN(BR_TAKEN),
        .IMM(IMM), .TARGET(TARGET), .REG_TGT(REG_TGT), .CLR_ERR(CLR_ERR),
        .PC(PC), .PC_INC(PC_INC), .RAS_CNT(RAS_CNT), .RAS_EMPTY(RAS_EMPTY),
        .RAS_FULL(RAS_FULL), .RAS_OVF(RAS_OVF), .RAS_UNF(RAS_UNF),
        .BAD_MODE(BAD_MODE), .LAST_REDIR(LAST_REDIR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cnt;
        logic [2:0]  flags;   // {BAD_MODE, RAS_UNF, RAS_OVF}
        logic [31:0] redir;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] e_pc = 32'h0;
    logic [31:0] e_redir = 32'h0;
    logic [3:0]  e_cnt = 4'd0;
    logic [2:0]  e_flags = 3'b000;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic load, input logic [2:0] mode,
                        input logic br, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic [31:0] rtgt, input logic clr,
                        input logic [31:0] exp_pc, input string name);
        exp_t e;
        @(negedge CLK);
        RST = rst_n; LOAD = load; MODE = mode; BR_TAKEN = br;
        IMM = imm; TARGET = tgt; REG_TGT = rtgt; CLR_ERR = clr;
`ifdef PC_UNIT_TRACE_EN
        if (!rst_n) e_redir = 32'h0;
        else if (load && ((mode inside {3'd2, 3'd3, 3'd4, 3'd5}) || (mode == 3'd1 && br)))
            e_redir = e_pc;
`endif
        e_pc    = exp_pc;
        e.pc    = exp_pc;
        e.cnt   = e_cnt;
        e.flags = e_flags;
        e.redir = e_redir;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic op(input logic [2:0] mode, input logic br, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic [31:0] rtgt,
                      input logic [31:0] exp_pc, input string name);
        step(1'b1, 1'b1, mode, br, imm, tgt, rtgt, 1'b0, exp_pc, name);
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pc", PC, e.pc);
                chk(e.name, "pc_inc", PC_INC, e.pc + 32'd1);
                chk(e.name, "cnt", {28'h0, RAS_CNT}, {28'h0, e.cnt});
                chk(e.name, "empty_full", {30'h0, RAS_EMPTY, RAS_FULL},
                    {30'h0, e.cnt == 4'd0, e.cnt == 4'd8});
                chk(e.name, "flags", {29'h0, BAD_MODE, RAS_UNF, RAS_OVF}, {29'h0, e.flags});
                chk(e.name, "last_redir", LAST_REDIR, e.redir);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0; LOAD = 1'b0; MODE = 3'd0; BR_TAKEN = 1'b0;
        IMM = 16'h0; TARGET = 26'h0; REG_TGT = 32'h0; CLR_ERR = 1'b0;

        // Reset must win over an active JUMP and CLR_ERR.
        step(1'b0, 1'b1, 3'd2, 1'b0, 16'h0, 26'h2222, 32'h0, 1'b1, 32'h1000, "reset0");
        step(1'b0, 1'b1, 3'd2, 1'b0, 16'h0, 26'h2222, 32'h0, 1'b0, 32'h1000, "reset1");

        op(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h1001, "inc1");
        op(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h1002, "inc2");
        op(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h1003, "inc3");

        op(3'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0, 32'h1000, "br_taken");
        op(3'd3, 1'b0, 16'h0, 26'h0, 32'h1003, 32'h1003, "jr_1003");
        op(3'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0, 32'h1004, "br_not_taken");
        op(3'd3, 1'b0, 16'h0, 26'h0, 32'h1000, 32'h1000, "jr_1000");

        e_cnt = 4'd1; op(3'd4, 1'b0, 16'h0, 26'h2000, 32'h0, 32'h2000, "call1");
        e_cnt = 4'd0; op(3'd5, 1'b0, 16'h0, 26'h0, 32'hDEAD, 32'h1001, "ret1");

        e_cnt = 4'd1; op(3'd4, 1'b0, 16'h0, 26'h2000, 32'h0, 32'h2000, "nest_call1");
        e_cnt = 4'd2; op(3'd4, 1'b0, 16'h0, 26'h3000, 32'h0, 32'h3000, "nest_call2");
        e_cnt = 4'd3; op(3'd4, 1'b0, 16'h0, 26'h4000, 32'h0, 32'h4000, "nest_call3");
        e_cnt = 4'd2; op(3'd5, 1'b0, 16'h0, 26'h0, 32'hDEAD, 32'h3001, "nest_ret3");
        e_cnt = 4'd1; op(3'd5, 1'b0, 16'h0, 26'h0, 32'hDEAD, 32'h2001, "nest_ret2");
        e_cnt = 4'd0; op(3'd5, 1'b0, 16'h0, 26'h0, 32'hDEAD, 32'h1002, "nest_ret1");

        // Nine calls into an eight-deep stack: the first link (0x1003) is lost.
        for (int k = 1; k <= 9; k++) begin
            e_cnt = (k > 8) ? 4'd8 : 4'(k);
            if (k == 9) e_flags[0] = 1'b1;
            op(3'd4, 1'b0, 16'h0, 26'(k * 256), 32'h0, 32'(k * 256), "ovf_call");
        end
        for (int j = 1; j <= 8; j++) begin
            e_cnt = 4'(8 - j);
            op(3'd5, 1'b0, 16'h0, 26'h0, 32'hDEAD, 32'(256 * (9 - j) + 1), "ovf_ret");
        end
        e_flags[1] = 1'b1;
        op(3'd5, 1'b0, 16'h0, 26'h0, 32'h3000, 32'h3000, "unf_ret");

        for (int h = 0; h < 4; h++)
            step(1'b1, 1'b0, 3'd2, 1'b0, 16'h0, 26'h0123, 32'h0, 1'b0, 32'h3000, "hold");

        e_flags[2] = 1'b1;
        op(3'd6, 1'b0, 16'h0, 26'h0, 32'h0, 32'h3001, "bad6");
        op(3'd7, 1'b0, 16'h0, 26'h0, 32'h0, 32'h3002, "bad7");

        e_flags = 3'b000;
        step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 32'h3002, "clr_err");
        e_flags = 3'b010;
        step(1'b1, 1'b1, 3'd5, 1'b0, 16'h0, 26'h0, 32'h3010, 1'b1, 32'h3010, "clr_vs_unf");
        e_flags = 3'b000;
        step(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 32'h3010, "clr_err2");

        op(3'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "jr_max");
        op(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_0000, "wrap_inc");
        op(3'd3, 1'b0, 16'h0, 26'h0, 32'h1000, 32'h1000, "jr_back");
        op(3'd3, 1'b0, 16'h0, 26'h0, 32'h4000, 32'h4000, "jr_4000");

        e_cnt = 4'd1; op(3'd4, 1'b0, 16'h0, 26'h2000, 32'h0, 32'h2000, "chain_call1");
        e_cnt = 4'd2; op(3'd4, 1'b0, 16'h0, 26'h3000, 32'h0, 32'h3000, "chain_call2");
        e_cnt = 4'd0;
        step(1'b0, 1'b1, 3'd5, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h1000, "chain_reset");
        e_flags = 3'b010;
        op(3'd5, 1'b0, 16'h0, 26'h0, 32'h5000, 32'h5000, "ret_after_reset");

        @(negedge CLK); LOAD = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised program-counter unit for the next-generation datapath. It replaces the fixed 32-bit preset PC register and its mux chain with a single block. The block:
- computes the next PC from one of six modes;
- carries a hardware return-address stack (RAS) for CALL/RET;
- reports stack status to the control unit.

It sits between the control unit (mode, load) and the instruction-memory address mux.

Parameters:
WIDTH, 32, PC/address width in bits; must be >= 26.
RESET_PC, 32'h0000_1000, PC value loaded on reset (project instruction start address), truncated to WIDTH.
RAS_DEPTH, 8, number of return-address entries; power of two, >= 2.
IMM_W, 16, branch offset width; sign-extended to WIDTH.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-low reset
LOAD  input  1  advance enable; 0 = hold all state
MODE  input  3  next-PC mode (encodings below)
BR_TAKEN  input  1  branch condition, used only in BRANCH mode
IMM  input  IMM_W  signed branch offset
TARGET  input  26  absolute jump target
REG_TGT  input  WIDTH  register-sourced target (JR, RET fallback)
CLR_ERR  input  1  clears sticky error flags
PC  output  WIDTH  current program counter
PC_INC  output  WIDTH  PC+1, combinational (link value)
RAS_CNT  output  clog2(RAS_DEPTH)+1  valid entries
RAS_EMPTY  output  1  RAS_CNT==0
RAS_FULL  output  1  RAS_CNT==RAS_DEPTH
RAS_OVF  output  1  sticky: CALL while full
RAS_UNF  output  1  sticky: RET while empty
BAD_MODE  output  1  sticky: reserved MODE seen with LOAD=1
LAST_REDIR  output  WIDTH  see Optional Feature

Behaviour:
- Reset is synchronous on a rising CLK with RST=0:
  - PC=RESET_PC; stack pointer=0; RAS_CNT=0.
  - All RAS entries=0; RAS_OVF=RAS_UNF=BAD_MODE=0; LAST_REDIR=0.
  - Reset overrides LOAD, MODE and CLR_ERR.
- All arithmetic is modulo 2^WIDTH; wrap-around is silent (PC max + 1 = 0).
- With LOAD=0, PC, RAS and flags hold. CLR_ERR still acts when LOAD=0.
- With LOAD=1, the next-PC update takes effect the following edge (1-cycle latency). PC_INC always tracks the current PC combinationally.
- MODE encodings:
  - 0 INC: PC<=PC+1.
  - 1 BRANCH: PC<=PC+1+sext(IMM) if BR_TAKEN, else PC+1.
  - 2 JUMP: PC<={zeros, TARGET}.
  - 3 JR: PC<=REG_TGT.
  - 4 CALL: PC<={zeros, TARGET}; push PC+1 onto the RAS.
  - 5 RET: PC<=top of RAS; pop.
  - 6, 7 reserved: PC<=PC+1 and BAD_MODE<=1.
- RAS is a circular LIFO.
  - CALL when full: overwrite the oldest entry (ring wraps); RAS_CNT stays at RAS_DEPTH; RAS_OVF<=1.
  - RET when empty: PC<=REG_TGT (software fallback); RAS_CNT stays 0; RAS_UNF<=1.
  - Push and pop never occur in the same cycle; MODE is one-hot in effect.
- CLR_ERR=1 clears all sticky flags at the next edge. If an error event occurs in the same cycle, the event wins and the flag is set.
- Reset asserted mid-sequence, e.g. between CALL and RET, discards all RAS contents.

Optional Feature:
Macro PC_UNIT_TRACE_EN.
- Defined: LAST_REDIR captures the source PC of every non-sequential update. This covers taken BRANCH, JUMP, JR, CALL and RET, but not INC, untaken BRANCH or reserved modes. Capture occurs on the same edge as the PC update.
- Undefined: LAST_REDIR is tied to 0 and no capture register is built.

Decomposition:
- Package pc_unit_pkg holds:
  - the MODE encodings (PCM_INC, PCM_BRANCH, PCM_JUMP, PCM_JR, PCM_CALL, PCM_RET);
  - the default RESET_PC constant;
  - the clog2 helper function.
- Sub-module ras_stack (parameters WIDTH, RAS_DEPTH) holds:
  - the entry array, pointer and count logic;
  - push/pop ports;
  - full/empty/ovf/unf outputs.
- The top level holds the PC register, next-PC mux and adders, and sticky-flag clear logic.

Test Plan:
- Reset, then 3 cycles of INC with LOAD=1 -> PC=0x1000, 0x1001, 0x1002, 0x1003; RAS_EMPTY=1.
- PC=0x1003, BRANCH with IMM=0xFFFC, BR_TAKEN=1 -> PC=0x1000. Repeat with BR_TAKEN=0 -> PC=0x1004.
- PC=0x1000, CALL TARGET=0x2000 -> PC=0x2000, RAS_CNT=1. RET -> PC=0x1001, RAS_EMPTY=1. Nested 3-deep CALL/RET returns in LIFO order.
- RAS_DEPTH=8: 9 CALLs from distinct PCs -> RAS_OVF=1, RAS_CNT=8. 8 RETs return the newest 8 link values; a 9th RET with REG_TGT=0x3000 -> PC=0x3000, RAS_UNF=1.
- LOAD=0 with MODE=JUMP for 4 cycles -> PC unchanged. MODE=6 with LOAD=1 -> PC+1, BAD_MODE=1. CLR_ERR pulse -> all flags 0.
- PC=0xFFFF_FFFF, INC -> PC=0. Reset asserted during a 2-deep call chain -> PC=0x1000, RAS_CNT=0 next edge. Under PC_UNIT_TRACE_EN, JR from 0x1000 to 0x4000 -> LAST_REDIR=0x1000.
